// File: rtl/aes_cbc_dec_ctrl_pkg.sv
// aes_cbc_dec_ctrl_pkg: shared constants for the AES CBC/ECB decipher controller.
package aes_cbc_dec_ctrl_pkg;

    // Block width of the AES data path.
    localparam int BLK_W = 128;

    // Chaining mode, sampled with each accepted ciphertext block.
    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    // Key-length selectors understood by the decipher core's key expansion.
    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_cbc_dec_ctrl_if.sv
// aes_cbc_dec_ctrl_if: ciphertext/plaintext streams, IV load and decipher-core handshake.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and data stable until
// that edge; ready may change freely and never depends on a transfer having
// already happened in the same cycle.
interface aes_cbc_dec_ctrl_if
    import aes_cbc_dec_ctrl_pkg::*;
#(
    parameter int CTR_W = 16
);
    logic             mode;
    logic             iv_we;
    logic [BLK_W-1:0] iv;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             core_next;
    logic [BLK_W-1:0] core_block;
    logic [BLK_W-1:0] core_result;
    logic             core_ready;
    logic             busy;
    logic [CTR_W-1:0] blk_ctr;

    // Environment side: supplies ciphertext/IV, consumes plaintext, models the core.
    modport master (
        output mode, iv_we, iv, in_valid, in_data, out_ready, core_result, core_ready,
        input  in_ready, out_valid, out_data, core_next, core_block, busy, blk_ctr
    );

    // Controller side.
    modport slave (
        input  mode, iv_we, iv, in_valid, in_data, out_ready, core_result, core_ready,
        output in_ready, out_valid, out_data, core_next, core_block, busy, blk_ctr
    );

endinterface

// File: rtl/aes_cbc_dec_ctrl.sv
// aes_cbc_dec_ctrl: runs one AES decipher operation per accepted ciphertext block,
// applies CBC chaining (or ECB pass-through) and holds the plaintext in a
// single-entry output register.
module aes_cbc_dec_ctrl
    import aes_cbc_dec_ctrl_pkg::*;
#(
    parameter int CTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    aes_cbc_dec_ctrl_if.slave  bus,
    output state_t             dbg_state_o
);

    state_t           state_q, state_d;
    logic [BLK_W-1:0] ct_q;
    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] out_q;
    logic             mode_q;
    logic             out_valid_q;
    logic [CTR_W-1:0] blk_ctr_q;

    logic             slot_free;
    logic             accept;
    logic             iv_load;
    logic             core_start;
    logic             complete;

    // Next-state decode and the single-cycle strobes that steer the datapath.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        iv_load    = 1'b0;
        core_start = 1'b0;
        complete   = 1'b0;
        // The output slot can take a new block if empty or being drained this cycle.
        slot_free  = !out_valid_q || bus.out_ready;
        case (state_q)
            ST_IDLE: begin
                accept  = bus.in_valid;
                iv_load = bus.iv_we;
                if (bus.in_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Core may still be busy (e.g. key expansion); hold off the pulse.
                if (bus.core_ready) begin
                    core_start = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Core result stays stable while the core is idle, so waiting
                // for a free output slot loses nothing.
                if (bus.core_ready && slot_free) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ciphertext capture, chaining value, output register and block counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ct_q        <= '0;
            chain_q     <= '0;
            mode_q      <= MODE_ECB;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            blk_ctr_q   <= '0;
        end else begin
            if (accept) begin
                ct_q   <= bus.in_data;
                mode_q <= bus.mode;
            end

            // Completion and IV load live in different states, so never collide.
            // The ciphertext always becomes the next chaining value, even in
            // ECB, so a later switch to CBC chains from the last block.
            if (complete) begin
                chain_q <= ct_q;
            end else if (iv_load) begin
                chain_q <= bus.iv;
            end

            if (complete) begin
                blk_ctr_q <= blk_ctr_q + CTR_W'(1);
            end else if (iv_load) begin
                blk_ctr_q <= '0;
            end

            // A reload in the same cycle as a drain keeps valid high (no bubble).
            if (complete) begin
                out_q       <= (mode_q == MODE_CBC) ? (bus.core_result ^ chain_q)
                                                    : bus.core_result;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.core_next  = core_start;
    assign bus.core_block = ct_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_q;
    assign bus.blk_ctr    = blk_ctr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// tb_aes_cbc_dec_ctrl: directed AES vectors plus randomized traffic against a
// block-level CBC/ECB reference model and a behavioural decipher-core model.
module tb_aes_cbc_dec_ctrl;
    import aes_cbc_dec_ctrl_pkg::*;

    localparam logic [127:0] CT_ECB = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_ECB = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0    = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT1    = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT0    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT1    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset_n;
    state_t dbg_state;

    always #5 clk = ~clk;

    aes_cbc_dec_ctrl_if #(.CTR_W(16)) bus ();

    aes_cbc_dec_ctrl #(.CTR_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_pulses = 0;
    logic [127:0]  exp_q[$];
    logic [127:0]  m_chain = '0;
    logic [15:0]   m_ctr   = '0;
    logic [127:0]  last_out = '0;
    logic [127:0]  prev_out = '0;

    int            sink_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic          core_hold = 1'b0;
    int            lat_lo = 4;
    int            lat_hi = 4;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raw AES-decipher output: exact for the known vectors (plaintext XOR the
    // chaining value that the standard vector uses), a bijective stand-in otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] ct);
        if (ct == CT_ECB) return PT_ECB;
        if (ct == CT0)    return PT0 ^ IV_CBC;
        if (ct == CT1)    return PT1 ^ CT0;
        return {ct[63:0], ct[127:64]} ^ 128'h5a5a_c3c3_0ff0_1234_a5a5_3c3c_f00f_4321;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- decipher core model ----------------
    logic [127:0] pending;
    int           core_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.core_ready  <= 1'b1;
            bus.core_result <= '0;
            core_cnt        <= 0;
            pending         <= '0;
        end else if (core_cnt > 0) begin
            if (core_cnt == 1) begin
                bus.core_ready  <= 1'b1;
                bus.core_result <= core_fn(pending);
            end
            core_cnt <= core_cnt - 1;
        end else if (bus.core_next && bus.core_ready) begin
            bus.core_ready <= 1'b0;
            pending        <= bus.core_block;
            core_cnt       <= $urandom_range(lat_hi, lat_lo);
        end else begin
            bus.core_ready <= !core_hold;
        end
    end

    // ---------------- output sink ----------------
    always begin
        @(posedge clk);
        #2;
        case (sink_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(9, 0) < 7);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.core_next) n_pulses++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    check("out_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) begin
                        prev_out = last_out;
                        last_out = exp_q.pop_front();
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic m, input logic load_iv,
                        input logic [127:0] ivv);
        int t = 0;
        logic [127:0] e;
        bus.in_data  = ct;
        bus.mode     = m;
        bus.iv       = ivv;
        bus.iv_we    = load_iv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", bus.in_ready, 1'b1);
        end else begin
            if (load_iv) begin
                m_chain = ivv;
                m_ctr   = '0;
            end
            e = (m == MODE_CBC) ? (core_fn(ct) ^ m_chain) : core_fn(ct);
            exp_q.push_back(e);
            m_chain = ct;
            m_ctr   = m_ctr + 16'd1;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.iv_we    = 1'b0;
    endtask

    task automatic load_iv(input logic [127:0] v);
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) check("iv_timeout", bus.busy, 1'b0);
        bus.iv    = v;
        bus.iv_we = 1'b1;
        m_chain   = v;
        m_ctr     = '0;
        tick();
        bus.iv_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        sink_mode = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready",   bus.in_ready,   1'b1);
        check("rst_out_valid",  bus.out_valid,  1'b0);
        check("rst_out_data",   bus.out_data,   '0);
        check("rst_core_next",  bus.core_next,  1'b0);
        check("rst_core_block", bus.core_block, '0);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_blk_ctr",    bus.blk_ctr,    '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bus.mode     = 1'b0;
        bus.iv_we    = 1'b0;
        bus.iv       = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        tick();
        reset_n = 1'b1;
        tick();

        // ECB vector with fixed core latency 4. Acceptance edge T: core_next
        // in cycle T+1, core busy T+2..T+5, ready seen T+6, out_valid in T+7.
        lat_lo = 4; lat_hi = 4;
        send(CT_ECB, MODE_ECB, 1'b0, '0);
        @(negedge clk);
        check("ecb_next", bus.core_next, 1'b1);
        check("ecb_block", bus.core_block, CT_ECB);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ecb_latency", n, 6);
        drain();
        check("ecb_pt", last_out, PT_ECB);
        check("ecb_ctr", bus.blk_ctr, 16'd1);

        // CBC two-block vector.
        load_iv(IV_CBC);
        lat_lo = 1; lat_hi = 5;
        send(CT0, MODE_CBC, 1'b0, '0);
        send(CT1, MODE_CBC, 1'b0, '0);
        drain();
        check("cbc_pt0", prev_out, PT0);
        check("cbc_pt1", last_out, PT1);
        check("cbc_ctr", bus.blk_ctr, 16'd2);

        // Consumer stalls across two CBC blocks; second waits in WAIT.
        load_iv(IV_CBC);
        lat_lo = 3; lat_hi = 3;
        sink_mode = 2;
        send(CT0, MODE_CBC, 1'b0, '0);
        send(CT1, MODE_CBC, 1'b0, '0);
        repeat (12) tick();
        @(negedge clk);
        check("stall_state", dbg_state, ST_WAIT);
        check("stall_in_ready", bus.in_ready, 1'b0);
        check("stall_out_valid", bus.out_valid, 1'b1);
        check("stall_out_data", bus.out_data, PT0);
        tick();
        sink_mode = 0;
        tick();
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 1'b1);
        check("b2b_data", bus.out_data, PT1);
        drain();
        check("stall_ctr", bus.blk_ctr, 16'd2);

        // iv_we while in WAIT must be ignored (chain and counter untouched).
        lat_lo = 8; lat_hi = 8;
        send(rand128(), MODE_CBC, 1'b0, '0);
        repeat (3) tick();
        @(negedge clk);
        check("ivw_state", dbg_state, ST_WAIT);
        bus.iv    = rand128();
        bus.iv_we = 1'b1;
        tick();
        bus.iv_we = 1'b0;
        send(rand128(), MODE_CBC, 1'b0, '0);
        drain();
        check("ivw_ctr", bus.blk_ctr, m_ctr);

        // iv_we together with acceptance: new IV used, counter 0 then 1.
        lat_lo = 2; lat_hi = 4;
        send(rand128(), MODE_CBC, 1'b1, rand128());
        @(negedge clk);
        check("ivacc_ctr0", bus.blk_ctr, 16'd0);
        drain();
        check("ivacc_ctr1", bus.blk_ctr, 16'd1);

        // Core not ready in START for 5 cycles: no pulse, then exactly one.
        lat_lo = 2; lat_hi = 2;
        core_hold = 1'b1;
        tick();
        tick();
        n_pulses = 0;
        send(rand128(), MODE_ECB, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_next", bus.core_next, 1'b0);
            check("hold_state", dbg_state, ST_START);
            tick();
        end
        core_hold = 1'b0;
        repeat (10) tick();
        check("hold_pulses", n_pulses, 1);
        drain();

        // Randomized traffic: mixed modes, sporadic IV loads, random stalls.
        lat_lo = 1; lat_hi = 5;
        sink_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(rand128(), 1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0), rand128());
            repeat ($urandom_range(2, 0)) tick();
        end
        drain();
        check("rand_ctr", bus.blk_ctr, m_ctr);

        // Reset in the middle of WAIT, then a clean block.
        lat_lo = 10; lat_hi = 10;
        send(rand128(), MODE_CBC, 1'b0, '0);
        repeat (3) tick();
        @(negedge clk);
        check("mid_rst_state", dbg_state, ST_WAIT);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        m_chain  = '0;
        m_ctr    = '0;
        last_out = '0;
        tick();
        reset_n = 1'b1;
        tick();
        lat_lo = 4; lat_hi = 4;
        send(CT_ECB, MODE_ECB, 1'b0, '0);
        drain();
        check("post_rst_pt", last_out, PT_ECB);
        check("post_rst_ctr", bus.blk_ctr, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_cbc_dec_ctrl.md
# aes_cbc_dec_ctrl

Block-mode controller directly downstream of, and driving, the AES decipher block (`next`, `block`, `new_block`, `ready` ports). It accepts 128-bit ciphertext blocks on a valid/ready stream and sequences one decipher operation per block. It XORs the decipher result with the chaining value in CBC mode, or passes it through in ECB mode. It delivers plaintext on an output valid/ready stream with a single-entry output register. Key expansion and round-key delivery are outside this block.

## Interface
Parameters:
- `CTR_W`, default 16: width of the completed-block counter.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `mode`, in, 1: 0 = ECB, 1 = CBC. Sampled at input acceptance.
- `iv_we`, in, 1: load `iv` into the chaining register. Honoured only in IDLE.
- `iv`, in, 128: initialisation vector.
- `in_valid`, in, 1: ciphertext available.
- `in_ready`, out, 1: controller can accept ciphertext.
- `in_data`, in, 128: ciphertext block.
- `out_valid`, out, 1: plaintext available.
- `out_ready`, in, 1: consumer takes plaintext.
- `out_data`, out, 128: plaintext block.
- `core_next`, out, 1: single-cycle start pulse to the decipher core.
- `core_block`, out, 128: ciphertext to the core. Equals `ct_reg`.
- `core_result`, in, 128: core `new_block`.
- `core_ready`, in, 1: core `ready`.
- `busy`, out, 1: state != IDLE.
- `blk_ctr`, out, CTR_W: number of blocks written to the output register since reset or the last IV load.

## Operation
- Registers: `ct_reg`[128], `chain_reg`[128], `mode_reg`, `out_reg`[128], `out_valid_reg`, `blk_ctr_reg`, and a 2-bit FSM. All registers reset to 0; FSM resets to IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `ct_reg`<=`in_data`, `mode_reg`<=`mode`, go to START.
  - `iv_we`: `chain_reg`<=`iv`, `blk_ctr`<=0.
  - If `iv_we` and acceptance occur in the same cycle, both happen. The accepted block uses the new IV.
- START:
  - If `core_ready`=1: `core_next`=1 for this cycle only, go to WAIT.
  - Otherwise stay in START with `core_next`=0 (core busy, e.g. key init).
- WAIT:
  - The core drops `ready` the cycle after `next`, so `core_ready` is 0 on entry.
  - When `core_ready`=1 and the output slot is free (`out_valid_reg`=0, or `out_valid_reg` & `out_ready` this cycle):
    - `out_reg`<= `core_result ^ chain_reg` if `mode_reg`=1, else `core_result`.
    - `out_valid_reg`<=1.
    - `chain_reg`<=`ct_reg` (both modes).
    - `blk_ctr`++ (wraps to 0 after all-ones).
    - Go to IDLE.
  - If the slot is occupied, stay in WAIT. `core_result` stays stable because the core is idle.
- Output: `out_valid_reg` clears on `out_valid` & `out_ready` unless reloaded in the same cycle. `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `iv_we` outside IDLE is ignored. `in_valid` outside IDLE is not accepted.
- Mid-operation reset clears everything. The core shares `reset_n`, so both return to idle together.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `core_next`=0, `core_block`=0, `busy`=0, `blk_ctr`=0.
- Acceptance at edge T → `core_next` in cycle T+1 (core ready) → core INIT in T+2. `core_block` is already registered and held for the whole operation.
- Completion: `out_valid` rises the cycle after `core_ready` is seen high in WAIT (slot free).
- `in_ready` rises in the same cycle as `out_valid`.
- Throughput: one block per (core latency + 3) cycles when the consumer does not stall.
- Back-to-back output: `out_ready`=1 with a simultaneous completion loads the new block with no bubble.

## Structure
- Shared package holds `MODE_ECB`/`MODE_CBC` and FSM state encodings (IDLE, START, WAIT), alongside the core's key-length constants.
- No sub-module inside this block. The top level instantiates the decipher block beside it and connects `core_*`.

## Test plan
- ECB, key 000102…0f (AES-128), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> `out_data` 00112233445566778899aabbccddeeff, `blk_ctr`=1.
- CBC per SP800-38A F.2.2, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f, ct 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2 -> 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51.
- Hold `out_ready`=0 during two CBC blocks -> the second block waits in WAIT, `in_ready`=0, first `out_data` stable; releasing `out_ready` delivers the second block the next cycle with correct chaining.
- `iv_we` in WAIT -> ignored, `chain_reg` unchanged. `iv_we` plus acceptance in IDLE -> new IV used, `blk_ctr`=0 then 1.
- Hold `core_ready`=0 in START for 5 cycles -> no `core_next` until it rises, then exactly one pulse.
- Assert `reset_n`=0 mid-WAIT -> all outputs at reset values immediately; a new block after release decrypts correctly.
